// File: rtl/gray_counter.sv
// Up/down Gray-code counter with registered binary and Gray outputs,
// synchronous load, and wrap or saturate behaviour at the ends of the range.
module gray_counter #(
    parameter int unsigned WIDTH     = 3,
    parameter bit          SATURATE  = 1'b0,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    output logic             tc
);

    localparam logic [WIDTH-1:0] RST_BIN  = RESET_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);

    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] b_nxt;
    logic [WIDTH-1:0] gray_q;
    logic             tc_q;
    logic             tc_nxt;
    logic             boundary;

    always_comb begin
        b_nxt    = b;
        tc_nxt   = 1'b0;
        boundary = 1'b0;
        if (load) begin
            b_nxt = load_bin;
        end else if (en) begin
            boundary = up_dn ? (&b) : (~|b);
            tc_nxt   = boundary;
            if (boundary && SATURATE) begin
                b_nxt = b;
            end else if (up_dn) begin
                b_nxt = b + 1'b1;
            end else begin
                b_nxt = b - 1'b1;
            end
        end
    end

    // Gray is encoded from b_nxt so it is a clean register output, never a decode of binary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b      <= RST_BIN;
            gray_q <= RST_GRAY;
            tc_q   <= 1'b0;
        end else begin
            b      <= b_nxt;
            gray_q <= b_nxt ^ (b_nxt >> 1);
            tc_q   <= tc_nxt;
        end
    end

    assign binary = b;
    assign gray   = gray_q;
    assign tc     = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter: 3-bit wrap, 3-bit saturate and 8-bit
// wrap instances sharing one clock and reset.
module tb_gray_counter;

    logic clk;
    logic rst_n;

    logic       en_a, up_a, load_a;
    logic [2:0] lb_a, bin_a, gray_a;
    logic       tc_a;

    logic       en_b, up_b, load_b;
    logic [2:0] lb_b, bin_b, gray_b;
    logic       tc_b;

    logic       en_c, up_c, load_c;
    logic [7:0] lb_c, bin_c, gray_c;
    logic       tc_c;

    int passed = 0;
    int total  = 0;

    gray_counter #(.WIDTH(3), .SATURATE(1'b0), .RESET_VAL(0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .up_dn(up_a), .load(load_a),
        .load_bin(lb_a), .binary(bin_a), .gray(gray_a), .tc(tc_a)
    );

    gray_counter #(.WIDTH(3), .SATURATE(1'b1), .RESET_VAL(0)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .up_dn(up_b), .load(load_b),
        .load_bin(lb_b), .binary(bin_b), .gray(gray_b), .tc(tc_b)
    );

    gray_counter #(.WIDTH(8), .SATURATE(1'b0), .RESET_VAL(200)) u_c (
        .clk(clk), .rst_n(rst_n), .en(en_c), .up_dn(up_c), .load(load_c),
        .load_bin(lb_c), .binary(bin_c), .gray(gray_c), .tc(tc_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [2:0] gseq [8];
    logic [2:0] pg3;
    logic [7:0] pg8;
    logic [7:0] exp8;
    logic       exp_tc;
    int         tc_pulses;

    initial begin
        gseq = '{3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4, 3'd0};
        rst_n = 1'b0;
        en_a = 1'b0; up_a = 1'b0; load_a = 1'b0; lb_a = '0;
        en_b = 1'b0; up_b = 1'b0; load_b = 1'b0; lb_b = '0;
        en_c = 1'b0; up_c = 1'b0; load_c = 1'b0; lb_c = '0;

        tick();
        check("rst_a_bin", bin_a, 0);
        check("rst_a_gray", gray_a, 0);
        check("rst_a_tc", tc_a, 0);
        check("rst_c_bin", bin_c, 200);
        // 200 = 1100_1000 -> Gray 1010_1100
        check("rst_c_gray", gray_c, 8'hAC);
        check("rst_c_tc", tc_c, 0);
        rst_n = 1'b1;

        // 3-bit up count through wrap
        en_a = 1'b1; up_a = 1'b1;
        pg3 = 3'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("up_bin", bin_a, (i + 1) % 8);
            check("up_gray", gray_a, gseq[i]);
            check("up_tc", tc_a, (i == 7) ? 1 : 0);
            check("up_onebit", $countones(gray_a ^ pg3), 1);
            pg3 = gray_a;
        end

        // Asynchronous reset mid-cycle while tc is high
        #2 rst_n = 1'b0;
        #1;
        check("arst_tc_bin", bin_a, 0);
        check("arst_tc_gray", gray_a, 0);
        check("arst_tc_tc", tc_a, 0);
        #2 rst_n = 1'b1;

        repeat (3) tick();
        check("pre_arst_bin", bin_a, 3);
        check("pre_arst_gray", gray_a, 2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_mid_bin", bin_a, 0);
        check("arst_mid_gray", gray_a, 0);
        check("arst_mid_tc", tc_a, 0);
        #2 rst_n = 1'b1;

        // Down count from 0 wraps to 7
        up_a = 1'b0;
        tick();
        check("dn_wrap_bin", bin_a, 7);
        check("dn_wrap_gray", gray_a, 4);
        check("dn_wrap_tc", tc_a, 1);
        tick();
        check("dn_bin", bin_a, 6);
        check("dn_gray", gray_a, 5);
        check("dn_tc", tc_a, 0);
        en_a = 1'b0;
        tick();
        check("hold_bin", bin_a, 6);
        check("hold_tc", tc_a, 0);

        // Load beats enable and never raises tc
        load_a = 1'b1; lb_a = 3'd7; en_a = 1'b1; up_a = 1'b1;
        tick();
        check("load_bin", bin_a, 7);
        check("load_gray", gray_a, 4);
        check("load_tc", tc_a, 0);
        load_a = 1'b0;
        tick();
        check("after_load_bin", bin_a, 0);
        check("after_load_tc", tc_a, 1);
        load_a = 1'b1; lb_a = 3'd0; up_a = 1'b0;
        tick();
        check("load_zero_bin", bin_a, 0);
        check("load_zero_tc", tc_a, 0);
        load_a = 1'b0; en_a = 1'b0;

        // Saturating instance
        en_b = 1'b1; up_b = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            check("sat_up_bin", bin_b, i + 1);
            check("sat_up_tc", tc_b, 0);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            check("sat_hold_bin", bin_b, 7);
            check("sat_hold_gray", gray_b, 4);
            check("sat_hold_tc", tc_b, 1);
        end
        en_b = 1'b0;
        tick();
        check("sat_drop_bin", bin_b, 7);
        check("sat_drop_tc", tc_b, 0);
        load_b = 1'b1; lb_b = 3'd0;
        tick();
        load_b = 1'b0; en_b = 1'b1; up_b = 1'b0;
        tick();
        check("sat_low_bin", bin_b, 0);
        check("sat_low_gray", gray_b, 0);
        check("sat_low_tc", tc_b, 1);
        en_b = 1'b0;

        // 8-bit sweep: 256 up-steps from 200 back to 200
        en_c = 1'b1; up_c = 1'b1;
        exp8 = 8'd200;
        tc_pulses = 0;
        for (int i = 0; i < 256; i++) begin
            pg8 = gray_c;
            exp_tc = (exp8 == 8'd255);
            exp8 = exp8 + 8'd1;
            tick();
            check("sw_bin", bin_c, exp8);
            check("sw_gray", gray_c, exp8 ^ (exp8 >> 1));
            check("sw_tc", tc_c, exp_tc);
            check("sw_onebit", $countones(gray_c ^ pg8), 1);
            if (tc_c === 1'b1) tc_pulses++;
        end
        en_c = 1'b0;
        check("sw_final_bin", bin_c, 200);
        check("sw_tc_pulses", tc_pulses, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
